// File: rtl/top_pkg.sv
// top_pkg: shared lane geometry and opcode encoding for the four-lane ALU.
package top_pkg;
    localparam int LANES  = 4;
    localparam int LANE_W = 64;
    localparam int OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        OP_PASS  = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_XOR   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_ROTL  = 4'd6,
        OP_SHR   = 4'd7,
        OP_REV   = 4'd8,
        OP_MAX   = 4'd9,
        OP_MIN   = 4'd10,
        OP_NOT   = 4'd11,
        OP_CLR   = 4'd12,
        OP_HOLD0 = 4'd13,
        OP_HOLD1 = 4'd14,
        OP_HOLD2 = 4'd15
    } op_t;
endpackage

// File: rtl/top_lane_alu.sv
// top_lane_alu: combinational result of one lane given its neighbour and mirror lanes.
module top_lane_alu
    import top_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic [LANE_W-1:0] rev,
    output logic [LANE_W-1:0] result
);
    logic [5:0]          w_sh;
    logic [2*LANE_W-1:0] w_dbl;
    assign w_sh  = b[5:0];
    // Rotating a doubled word keeps amount 0 an identity with no out-of-range shift.
    assign w_dbl = {a, a} << w_sh;
    always_comb begin
        result = '0;
        case (op_t'(op))
            OP_PASS: result = a;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_XOR:  result = a ^ b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ROTL: result = w_dbl[2*LANE_W-1:LANE_W];
            OP_SHR:  result = a >> w_sh;
            OP_REV:  result = rev;
            OP_MAX:  result = (a > b) ? a : b;
            OP_MIN:  result = (a < b) ? a : b;
            OP_NOT:  result = ~a;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/top.sv
// top: four-lane 64-bit ALU with registered results, running accumulator, op counter and flags.
module top
    import top_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [259:0] in_flat,
    output logic [329:0] out_flat
);
    logic [OP_W-1:0]         w_op;
    logic                    w_clr;
    logic                    w_hold;
    logic [LANES*LANE_W-1:0] w_res;
    logic [LANES*LANE_W-1:0] w_new;
    logic [LANES*LANE_W-1:0] r_res;
    logic [LANE_W-1:0]       r_acc;
    logic [7:0]              r_cnt;
    logic                    r_zero;
    logic                    r_par;

    assign w_op   = in_flat[LANES*LANE_W +: OP_W];
    assign w_clr  = w_op == OP_CLR;
    assign w_hold = w_op >= OP_HOLD0;
    assign w_new  = w_clr ? '0 : w_res;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        top_lane_alu u_alu (
            .op     (w_op),
            .a      (in_flat[LANE_W*k +: LANE_W]),
            .b      (in_flat[LANE_W*((k+1)%LANES) +: LANE_W]),
            .rev    (in_flat[LANE_W*(LANES-1-k) +: LANE_W]),
            .result (w_res[LANE_W*k +: LANE_W])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res  <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_zero <= 1'b0;
            r_par  <= 1'b0;
        end else if (!w_hold) begin
            r_res  <= w_new;
            r_acc  <= w_clr ? '0 : r_acc + w_new[LANE_W-1:0];
            r_cnt  <= r_cnt + 8'd1;
            r_zero <= ~|w_new;
            r_par  <= ^w_new;
        end
    end

    assign out_flat = {r_par, r_zero, r_cnt, r_acc, r_res};
endmodule

// File: tb/tb_top.sv
// tb_top: vector table, directed corner sequences and randomized run against a lane-level reference model.
module tb_top;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [259:0] in_flat = '0;
    logic [329:0] out_flat;

    int tests = 0;
    int fails = 0;

    logic [63:0] m_res [4];
    logic [63:0] m_acc;
    logic [7:0]  m_cnt;
    logic        m_zero;
    logic        m_par;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] l0, l1, l2, l3;
        logic [63:0] exp_r0;
    } vec_t;

    top dut (.clk(clk), .rst_n(rst_n), .in_flat(in_flat), .out_flat(out_flat));

    always #5 clk = ~clk;

    function automatic logic [259:0] mk(input logic [3:0] op, input logic [63:0] l0, l1, l2, l3);
        return {op, l3, l2, l1, l0};
    endfunction

    function automatic logic [63:0] ref_lane(input int op, input logic [63:0] a, b, rv);
        int s;
        s = int'(b % 64);
        case (op)
            0:  return a;
            1:  return a + b;
            2:  return a - b;
            3:  return a ^ b;
            4:  return a & b;
            5:  return a | b;
            6:  return (s == 0) ? a : ((a << s) | (a >> (64 - s)));
            7:  return a >> s;
            8:  return rv;
            9:  return (a > b) ? a : b;
            10: return (a < b) ? a : b;
            11: return ~a;
            default: return 64'd0;
        endcase
    endfunction

    task automatic model(input logic r, input logic [259:0] v);
        int op;
        logic [63:0] ln [4];
        logic [255:0] all;
        op = int'(v[259:256]);
        for (int k = 0; k < 4; k++) ln[k] = v[64*k +: 64];
        if (!r) begin
            for (int k = 0; k < 4; k++) m_res[k] = 0;
            m_acc = 0; m_cnt = 0; m_zero = 0; m_par = 0;
        end else if (op <= 12) begin
            for (int k = 0; k < 4; k++) m_res[k] = ref_lane(op, ln[k], ln[(k + 1) % 4], ln[3 - k]);
            m_acc = (op == 12) ? 64'd0 : m_acc + m_res[0];
            m_cnt = m_cnt + 1;
            all = {m_res[3], m_res[2], m_res[1], m_res[0]};
            m_zero = (all == 0);
            m_par = ^all;
        end
    endtask

    function automatic logic [329:0] expected();
        return {m_par, m_zero, m_cnt, m_acc, m_res[3], m_res[2], m_res[1], m_res[0]};
    endfunction

    task automatic chk(input string name, input logic [329:0] act, input logic [329:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [259:0] v);
        rst_n = r;
        in_flat = v;
        @(posedge clk);
        #1;
        model(r, v);
    endtask

    vec_t vecs [14];
    logic [329:0] saved;
    logic [7:0]   c;
    logic [3:0]   rop;
    logic [63:0]  rl [4];

    initial begin
        vecs[0]  = '{4'd0,  64'd5, 64'd0, 64'd0, 64'd0, 64'd5};
        vecs[1]  = '{4'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 64'd0};
        vecs[2]  = '{4'd2,  64'd3, 64'd5, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[3]  = '{4'd3,  64'hA, 64'hC, 64'd0, 64'd0, 64'h6};
        vecs[4]  = '{4'd4,  64'hA, 64'hC, 64'd0, 64'd0, 64'h8};
        vecs[5]  = '{4'd5,  64'hA, 64'hC, 64'd0, 64'd0, 64'hE};
        vecs[6]  = '{4'd6,  64'h8000_0000_0000_0001, 64'd1, 64'd0, 64'd0, 64'h3};
        vecs[7]  = '{4'd7,  64'h8000_0000_0000_0001, 64'd1, 64'd0, 64'd0, 64'h4000_0000_0000_0000};
        vecs[8]  = '{4'd8,  64'd1, 64'd2, 64'd3, 64'h77, 64'h77};
        vecs[9]  = '{4'd9,  64'd3, 64'd9, 64'd0, 64'd0, 64'd9};
        vecs[10] = '{4'd10, 64'd3, 64'd9, 64'd0, 64'd0, 64'd3};
        vecs[11] = '{4'd11, 64'd0, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[12] = '{4'd6,  64'h1234, 64'd64, 64'd0, 64'd0, 64'h1234};
        vecs[13] = '{4'd7,  64'h8000_0000_0000_0000, 64'd63, 64'd0, 64'd0, 64'd1};

        // Reset for two edges with garbage inputs, then the first live edge counts once.
        for (int i = 0; i < 2; i++) begin
            step(1'b0, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 4'($urandom)});
            chk("reset_zero", out_flat, 330'd0);
        end
        step(1'b1, mk(4'd0, 64'd9, 64'd0, 64'd0, 64'd0));
        chk("first_cnt", {322'd0, out_flat[327:320]}, 330'd1);

        // Each vector follows a CLR so acc must equal the new r0.
        foreach (vecs[i]) begin
            step(1'b1, mk(4'd12, 64'd0, 64'd0, 64'd0, 64'd0));
            step(1'b1, mk(vecs[i].op, vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].l3));
            chk($sformatf("vec%0d_r0", i), {266'd0, out_flat[63:0]}, {266'd0, vecs[i].exp_r0});
            chk($sformatf("vec%0d_acc", i), {266'd0, out_flat[319:256]}, {266'd0, vecs[i].exp_r0});
            chk($sformatf("vec%0d_all", i), out_flat, expected());
        end

        step(1'b1, mk(4'd12, 64'd1, 64'd2, 64'd3, 64'd4));
        chk("clr_flags", {327'd0, out_flat[329:328], out_flat[319:256] == 64'd0}, {327'd0, 2'b01, 1'b1});
        step(1'b1, mk(4'd4, 64'hF0, 64'h0F, 64'hF0, 64'h0F));
        chk("and_zero_flag", {327'd0, out_flat[329:328], out_flat[319:256] == 64'd0}, {327'd0, 2'b01, 1'b1});
        step(1'b1, mk(4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd7, 64'd0));
        chk("add_wrap", out_flat, expected());

        // HOLD keeps everything for three cycles.
        step(1'b0, '0);
        step(1'b1, mk(4'd0, 64'd5, 64'd0, 64'd0, 64'd0));
        chk("hold_pre_acc", {266'd0, out_flat[319:256]}, 330'd5);
        saved = out_flat;
        c = out_flat[327:320];
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk(4'd14, $urandom, $urandom, $urandom, $urandom));
            chk("hold_stable", out_flat, saved);
        end
        step(1'b1, mk(4'd0, 64'd5, 64'd0, 64'd0, 64'd0));
        chk("hold_post", {258'd0, out_flat[327:256]}, {258'd0, c + 8'd1, 64'd10});

        // Counter wraps after 256 counted cycles, then reset mid-run clears it.
        step(1'b0, '0);
        for (int i = 0; i < 256; i++) step(1'b1, mk(4'd0, 64'd1, 64'd0, 64'd0, 64'd0));
        chk("cnt_wrap", {322'd0, out_flat[327:320]}, 330'd0);
        for (int i = 0; i < 5; i++) step(1'b1, mk(4'd0, 64'd3, 64'd0, 64'd0, 64'd0));
        step(1'b0, mk(4'd1, 64'd3, 64'd4, 64'd0, 64'd0));
        chk("mid_reset", {258'd0, out_flat[327:256]}, 330'd0);

        for (int i = 0; i < 400; i++) begin
            rop = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) rl[k] = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
            step(($urandom_range(0, 39) != 0), mk(rop, rl[0], rl[1], rl[2], rl[3]));
            chk($sformatf("rand%0d_op%0d", i, rop), out_flat, expected());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
